reg_cmd_sequencer: RTL and testbench

Upstream control stage for the register file. It turns a raw pushbutton plus the 4-bit op selector into clean single-cycle load_a / load_b / swap command pulses. Without it, a level-decoded op would reload or re-swap the registers on every clock. Its outputs drive the register file's load_a, load_b and swap inputs directly. It also exports a busy flag and a command counter for display and debug.

---
 rtl/reg_cmd_sequencer.sv | 136 +++++++++++++
 tb/tb_reg_cmd_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_cmd_sequencer.sv
// reg_cmd_sequencer: turns a raw, bouncing execute button plus a 4-bit op
// selector into clean single-cycle load_a / load_b / swap command pulses.
//
// Ports:
//   clk        - system clock, all state updates on the rising edge
//   reset      - synchronous, active-high reset
//   btn_exec   - raw asynchronous execute button
//   op         - operation selector (quasi-static switches)
//   load_a     - one-cycle pulse, op 4'b1111
//   load_b     - one-cycle pulse, op 4'b1101
//   swap       - one-cycle pulse, op 4'b1110
//   op_latched - op captured at the most recent accepted press
//   busy       - high while the sequencer is not idle
//   exec_count - number of issued register commands, modulo 256
module reg_cmd_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_exec,
  input  logic [3:0] op,
  output logic       load_a,
  output logic       load_b,
  output logic       swap,
  output logic [3:0] op_latched,
  output logic       busy,
  output logic [7:0] exec_count
);

  localparam logic [3:0] OP_LOAD_A = 4'b1111;
  localparam logic [3:0] OP_LOAD_B = 4'b1101;
  localparam logic [3:0] OP_SWAP   = 4'b1110;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ISSUE        = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  logic             s1;
  logic             s2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  state_t     state;
  state_t     next_state;
  logic       load_a_d;
  logic       load_b_d;
  logic       swap_d;
  logic       busy_d;
  logic [3:0] op_latched_d;
  logic [7:0] exec_count_d;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_exec;
      s2 <= s1;
    end
  end

  // Debouncer: accept a new level only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (s2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt    <= '0;
      stable <= s2;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      load_a     <= 1'b0;
      load_b     <= 1'b0;
      swap       <= 1'b0;
      busy       <= 1'b0;
      op_latched <= 4'd0;
      exec_count <= 8'd0;
    end else begin
      state      <= next_state;
      load_a     <= load_a_d;
      load_b     <= load_b_d;
      swap       <= swap_d;
      busy       <= busy_d;
      op_latched <= op_latched_d;
      exec_count <= exec_count_d;
    end
  end

  // Next-state and next-output decode; pulses are only armed on IDLE->ISSUE.
  always_comb begin
    next_state   = state;
    load_a_d     = 1'b0;
    load_b_d     = 1'b0;
    swap_d       = 1'b0;
    op_latched_d = op_latched;
    exec_count_d = exec_count;
    case (state)
      IDLE: begin
        if (stable) begin
          next_state   = ISSUE;
          op_latched_d = op;
          load_a_d     = (op == OP_LOAD_A);
          load_b_d     = (op == OP_LOAD_B);
          swap_d       = (op == OP_SWAP);
        end
      end
      ISSUE: begin
        next_state = WAIT_RELEASE;
        if (load_a || load_b || swap) begin
          exec_count_d = exec_count + 8'd1;
        end
      end
      WAIT_RELEASE: begin
        if (!stable) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    busy_d = (next_state != IDLE);
  end

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Self-checking bench for reg_cmd_sequencer with a small debounce window.
module tb_reg_cmd_sequencer;

  localparam int unsigned D    = 4;
  localparam int          MAXE = 40000;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_exec;
  logic [3:0] op;
  logic       load_a;
  logic       load_b;
  logic       swap;
  logic [3:0] op_latched;
  logic       busy;
  logic [7:0] exec_count;

  int n_tests = 0;
  int n_fail  = 0;

  reg_cmd_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_exec   (btn_exec),
    .op         (op),
    .load_a     (load_a),
    .load_b     (load_b),
    .swap       (swap),
    .op_latched (op_latched),
    .busy       (busy),
    .exec_count (exec_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: button history per edge, debounced level derived from a
  // window rule, and a press tracker (armed / pulsing / waiting for release).
  bit   btn_hist [MAXE];
  int   edge_n     = 0;
  int   last_reset = 0;
  int   last_flip  = 0;
  bit   m_stable   = 0;
  bit   m_armed    = 1;
  bit   m_pulsing  = 0;
  int   m_cmd      = 0;  // 0 none, 1 load_a, 2 load_b, 3 swap
  int   m_op       = 0;
  int   m_count    = 0;
  int   pulses     = 0;
  bit   chk_en     = 0;

  function automatic bit s2_before(input int e);
    if (e - 2 > last_reset) return btn_hist[e - 2];
    return 1'b0;
  endfunction

  function automatic int decode(input int o);
    case (o)
      15: return 1;
      13: return 2;
      14: return 3;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    bit flip;
    btn_hist[edge_n] = btn_exec;
    if (reset) begin
      last_reset = edge_n;
      last_flip  = edge_n;
      m_stable   = 0;
      m_armed    = 1;
      m_pulsing  = 0;
      m_cmd      = 0;
      m_op       = 0;
      m_count    = 0;
    end else begin
      // Debounced level flips once D consecutive synchronized samples disagree.
      flip = (edge_n - int'(D) >= last_reset) && (edge_n - int'(D) >= last_flip);
      for (int k = 0; k < int'(D); k++)
        if (flip && s2_before(edge_n - k) == m_stable) flip = 0;
      if (m_pulsing) begin
        if (m_cmd != 0) m_count = (m_count + 1) % 256;
        m_pulsing = 0;
        m_cmd     = 0;
      end else if (m_armed && m_stable) begin
        m_armed   = 0;
        m_pulsing = 1;
        m_op      = op;
        m_cmd     = decode(op);
        if (m_cmd != 0) pulses++;
      end else if (!m_armed && !m_stable) begin
        m_armed = 1;
      end
      if (flip) begin
        m_stable  = ~m_stable;
        last_flip = edge_n;
      end
    end
    edge_n++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("load_a",     int'(load_a),     int'(m_cmd == 1));
      check("load_b",     int'(load_b),     int'(m_cmd == 2));
      check("swap",       int'(swap),       int'(m_cmd == 3));
      check("busy",       int'(busy),       int'(!m_armed || m_pulsing));
      check("op_latched", int'(op_latched), m_op);
      check("exec_count", int'(exec_count), m_count);
    end
  end

  task automatic cycles(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic press(input logic [3:0] o, input int hold);
    @(negedge clk);
    op       = o;
    btn_exec = 1'b1;
    cycles(hold);
    btn_exec = 1'b0;
    cycles(int'(D) + 6);
  endtask

  task automatic bounce(input int len, input int period);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      btn_exec = ((i / period) % 2 == 0);
    end
    @(negedge clk);
    btn_exec = 1'b0;
    cycles(int'(D) + 6);
  endtask

  initial begin
    int p0;
    logic [3:0] ops [5] = '{4'hF, 4'hD, 4'hE, 4'h0, 4'h7};
    reset    = 1'b1;
    btn_exec = 1'b0;
    op       = 4'h0;
    cycles(3);
    reset  = 1'b0;
    chk_en = 1'b1;
    check("rst_busy",  int'(busy), 0);
    check("rst_count", int'(exec_count), 0);

    // Clean long press, load_a.
    press(4'hF, 50);
    check("first_count", int'(exec_count), 1);
    check("first_op",    int'(op_latched), 15);

    // Bouncing every 2 cycles never gets through.
    p0 = pulses;
    bounce(20, 2);
    check("bounce_pulses", pulses - p0, 0);
    check("bounce_count",  int'(exec_count), 1);

    // Op change during hold has no effect.
    @(negedge clk);
    op = 4'hE;
    btn_exec = 1'b1;
    cycles(int'(D) + 8);
    op = 4'hF;
    cycles(10);
    btn_exec = 1'b0;
    cycles(int'(D) + 6);
    check("swap_op", int'(op_latched), 14);
    check("swap_count", int'(exec_count), 2);

    // Sequential presses with a non-command op in between.
    do_reset();
    press(4'hD, 10);
    press(4'h0, 10);
    press(4'hF, 10);
    check("seq_count", int'(exec_count), 2);

    // Reset while waiting for release, button still held.
    @(negedge clk);
    op = 4'hF;
    btn_exec = 1'b1;
    cycles(int'(D) + 6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_hold_busy",  int'(busy), 0);
    check("rst_hold_count", int'(exec_count), 0);
    cycles(int'(D) + 6);
    check("rehold_count", int'(exec_count), 1);
    btn_exec = 1'b0;
    cycles(int'(D) + 6);

    // Counter wrap after 256 commands.
    do_reset();
    for (int i = 0; i < 256; i++) press(4'hF, 1 + $urandom_range(0, 4) + int'(D));
    check("wrap_count", int'(exec_count), 0);

    // Random mix of presses, glitches and ops.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: bounce($urandom_range(2, 12), $urandom_range(1, int'(D)));
        1: begin
          @(negedge clk);
          op = ops[$urandom_range(0, 4)];
          btn_exec = 1'($urandom_range(0, 1));
          cycles($urandom_range(1, 2 * int'(D) + 2));
        end
        default: press(ops[$urandom_range(0, 4)], $urandom_range(1, 3 * int'(D)));
      endcase
      if ($urandom_range(0, 30) == 0) do_reset();
    end
    btn_exec = 1'b0;
    cycles(int'(D) + 6);
    check("final_count", int'(exec_count), m_count);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
